// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle control FSM of the 16-bit datapath.
package mc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } mc_state_e;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_NAND = 4'b0101;
   localparam logic [3:0] OP_SLT  = 4'b0110;
   localparam logic [3:0] OP_ADDI = 4'b0111;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_NAND = 4'b1101;

endpackage

// File: rtl/mc_op_decode.sv
// Opcode to ALU function / operand-select decode; anything with op[3] set is illegal.
module mc_op_decode
   import mc_pkg::*;
(
   input  logic [3:0] op_q,
   output logic [3:0] alu_ctl,
   output logic       reg_dst,
   output logic       alu_src,
   output logic       legal
);

   always_comb begin
      alu_ctl = ALU_AND;
      reg_dst = 1'b1;
      alu_src = 1'b0;
      legal   = 1'b1;
      case (op_q)
         OP_ADD:  alu_ctl = ALU_ADD;
         OP_SUB:  alu_ctl = ALU_SUB;
         OP_AND:  alu_ctl = ALU_AND;
         OP_OR:   alu_ctl = ALU_OR;
         OP_NOR:  alu_ctl = ALU_NOR;
         OP_NAND: alu_ctl = ALU_NAND;
         OP_SLT:  alu_ctl = ALU_SLT;
         OP_ADDI: begin
            alu_ctl = ALU_ADD;
            reg_dst = 1'b0;
            alu_src = 1'b1;
         end
         default: begin
            reg_dst = 1'b0;
            legal   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// FETCH/DECODE/EXEC/WB sequencer with run/step control, illegal-opcode trap and retire counter.
module mc_control
   import mc_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        run,
   input  logic        step,
   input  logic [3:0]  ir_op,
   input  logic        imem_ack,
   output logic        imem_req,
   output logic        ir_load,
   output logic        pc_write,
   output logic        alu_out_load,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        alu_src,
   output logic [3:0]  alu_ctl,
   output logic        busy,
   output logic        illegal,
   output logic [15:0] retired
);

   mc_state_e   state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic        oneshot_q, oneshot_d;
   logic [15:0] retired_q, retired_d;

   logic [3:0]  dec_op, dec_alu_ctl;
   logic        dec_reg_dst, dec_alu_src, dec_legal;
   logic        in_exec_wb;

   // In DECODE the decoder looks at the live opcode so the trap decision needs no extra cycle.
   assign dec_op = (state_q == ST_DECODE) ? ir_op : op_q;

   mc_op_decode u_dec (
      .op_q    (dec_op),
      .alu_ctl (dec_alu_ctl),
      .reg_dst (dec_reg_dst),
      .alu_src (dec_alu_src),
      .legal   (dec_legal)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      oneshot_d = oneshot_q;
      retired_d = retired_q;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_FETCH;
            end else if (step) begin
               state_d   = ST_FETCH;
               oneshot_d = 1'b1;
            end
         end
         ST_FETCH: begin
            if (imem_ack) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            op_d    = ir_op;
            state_d = dec_legal ? ST_EXEC : ST_TRAP;
         end
         ST_EXEC: state_d = ST_WB;
         ST_WB: begin
            retired_d = retired_q + 16'd1;
            state_d   = (run && !oneshot_q) ? ST_FETCH : ST_IDLE;
            oneshot_d = 1'b0;
         end
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         op_q      <= 4'd0;
         oneshot_q <= 1'b0;
         retired_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         oneshot_q <= oneshot_d;
         retired_q <= retired_d;
      end
   end

   assign in_exec_wb   = (state_q == ST_EXEC) || (state_q == ST_WB);
   assign imem_req     = (state_q == ST_FETCH);
   assign ir_load      = imem_req && imem_ack;
   assign pc_write     = imem_req && imem_ack;
   assign alu_out_load = (state_q == ST_EXEC);
   assign reg_write    = (state_q == ST_WB);
   assign reg_dst      = in_exec_wb && dec_reg_dst;
   assign alu_src      = in_exec_wb && dec_alu_src;
   assign alu_ctl      = in_exec_wb ? dec_alu_ctl : 4'd0;
   assign busy         = (state_q != ST_IDLE) && (state_q != ST_TRAP);
   assign illegal      = (state_q == ST_TRAP);
   assign retired      = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Randomized and directed bench for mc_control against an instruction-phase reference model.
module tb_mc_control;

   logic        clock = 1'b0;
   logic        reset_n, run, step, imem_ack;
   logic [3:0]  ir_op;
   logic        imem_req, ir_load, pc_write, alu_out_load, reg_write, reg_dst, alu_src;
   logic [3:0]  alu_ctl;
   logic        busy, illegal;
   logic [15:0] retired;
   logic [28:0] outs;

   mc_control dut (
      .clock(clock), .reset_n(reset_n), .run(run), .step(step), .ir_op(ir_op),
      .imem_ack(imem_ack), .imem_req(imem_req), .ir_load(ir_load), .pc_write(pc_write),
      .alu_out_load(alu_out_load), .reg_write(reg_write), .reg_dst(reg_dst),
      .alu_src(alu_src), .alu_ctl(alu_ctl), .busy(busy), .illegal(illegal), .retired(retired)
   );

   always #5 clock = ~clock;

   assign outs = {imem_req, ir_load, pc_write, alu_out_load, reg_write, reg_dst, alu_src,
                  alu_ctl, busy, illegal, retired};

   localparam logic [3:0] ALU_TAB [8] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'hC, 4'hD, 4'h7, 4'h2};

   int tests = 0;
   int fails = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference model: position within the current instruction (0 none, 1..4 = cycle of it).
   int          m_pos = 0;
   bit          m_trap = 1'b0, m_oneshot = 1'b0;
   logic [3:0]  m_op = 4'd0;
   logic [15:0] m_ret = 16'd0;

   always @(posedge clock) begin
      if (!reset_n) begin
         m_pos = 0; m_trap = 1'b0; m_oneshot = 1'b0; m_op = 4'd0; m_ret = 16'd0;
      end else if (!m_trap) begin
         case (m_pos)
            0: if (run) m_pos = 1;
               else if (step) begin m_pos = 1; m_oneshot = 1'b1; end
            1: if (imem_ack) m_pos = 2;
            2: begin
               m_op = ir_op;
               if (ir_op >= 4'd8) begin m_trap = 1'b1; m_pos = 0; end
               else m_pos = 3;
            end
            3: m_pos = 4;
            default: begin
               m_ret = m_ret + 16'd1;
               m_pos = (run && !m_oneshot) ? 1 : 0;
               m_oneshot = 1'b0;
            end
         endcase
      end
   end

   int n_req = 0, n_irl = 0, n_rw = 0, n_busy = 0;
   logic [3:0] exq[$];

   always @(negedge clock) begin
      logic        ex;
      logic [28:0] e;
      ex = (m_pos == 3) || (m_pos == 4);
      e = {m_pos == 1, (m_pos == 1) && imem_ack, (m_pos == 1) && imem_ack, m_pos == 3, m_pos == 4,
           ex && (m_op != 4'd7), ex && (m_op == 4'd7), ex ? ALU_TAB[m_op[2:0]] : 4'd0,
           m_pos != 0, m_trap, m_ret};
      check("outputs", {3'd0, outs}, {3'd0, e});
      if (imem_req) n_req++;
      if (ir_load) n_irl++;
      if (reg_write) n_rw++;
      if (busy) n_busy++;
      if (alu_out_load) exq.push_back(alu_ctl);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; run = 1'b0; step = 1'b0; imem_ack = 1'b0;
      tick(2);
      @(negedge clock);
      check("reset_outputs", {3'd0, outs}, 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
   endtask

   task automatic wait_exec(input string nm);
      int w = 0;
      @(negedge clock);
      while (alu_out_load !== 1'b1 && w < 20) begin
         @(negedge clock);
         w++;
      end
      if (alu_out_load !== 1'b1) check(nm, {31'd0, alu_out_load}, 32'd1);
   endtask

   initial begin
      int rw0, req0, irl0, busy0, base;
      reset_n = 1'b0; run = 1'b0; step = 1'b0; imem_ack = 1'b0; ir_op = 4'd0;
      do_reset();

      // Free run of addi with zero-wait memory for 12 cycles.
      rw0 = n_rw;
      imem_ack = 1'b1; ir_op = 4'd7; run = 1'b1;
      tick(12);
      run = 1'b0;
      tick(3);
      check("run_retired", {16'd0, retired}, 32'd3);
      check("run_reg_writes", n_rw - rw0, 32'd3);

      // Sequence of R-type ops.
      base = exq.size();
      ir_op = 4'd0; run = 1'b1;
      for (int k = 0; k < 7; k++) begin
         ir_op = 4'(k);
         wait_exec($sformatf("seq_timeout%0d", k));
         if (k == 6) run = 1'b0;
      end
      tick(4);
      check("seq_count", exq.size() - base, 32'd7);
      if (exq.size() >= base + 7) begin
         check("seq_add",  {28'd0, exq[base+0]}, 32'h2);
         check("seq_sub",  {28'd0, exq[base+1]}, 32'h6);
         check("seq_and",  {28'd0, exq[base+2]}, 32'h0);
         check("seq_or",   {28'd0, exq[base+3]}, 32'h1);
         check("seq_nor",  {28'd0, exq[base+4]}, 32'hC);
         check("seq_nand", {28'd0, exq[base+5]}, 32'hD);
         check("seq_slt",  {28'd0, exq[base+6]}, 32'h7);
      end
      check("seq_retired", {16'd0, retired}, 32'd10);

      // Memory ack delayed by three cycles.
      req0 = n_req; irl0 = n_irl; busy0 = n_busy;
      imem_ack = 1'b0; ir_op = 4'd3; step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(3);
      imem_ack = 1'b1;
      tick(1);
      imem_ack = 1'b0;
      tick(5);
      check("wait_req_cycles", n_req - req0, 32'd4);
      check("wait_ir_load", n_irl - irl0, 32'd1);
      check("wait_busy_cycles", n_busy - busy0, 32'd7);

      // Two step pulses ten cycles apart.
      rw0 = n_rw; imem_ack = 1'b1; ir_op = 4'd1;
      step = 1'b1; tick(1); step = 1'b0;
      tick(5);
      check("step_idle_between", {31'd0, busy}, 32'd0);
      tick(4);
      step = 1'b1; tick(1); step = 1'b0;
      tick(6);
      check("step_reg_writes", n_rw - rw0, 32'd2);
      check("step_retired", {16'd0, retired}, 32'd13);

      // Illegal opcode traps and holds until reset.
      rw0 = n_rw; ir_op = 4'hA; run = 1'b1;
      tick(8);
      check("trap_illegal", {31'd0, illegal}, 32'd1);
      check("trap_busy", {31'd0, busy}, 32'd0);
      check("trap_no_write", n_rw - rw0, 32'd0);
      check("trap_retired", {16'd0, retired}, 32'd13);
      tick(3);
      do_reset();

      // Counter wrap from 0xFFFF.
      force dut.retired_q = 16'hFFFF;
      m_ret = 16'hFFFF;
      tick(1);
      release dut.retired_q;
      @(negedge clock);
      check("wrap_preload", {16'd0, retired}, 32'hFFFF);
      @(posedge clock); #1;
      imem_ack = 1'b1; ir_op = 4'd2; step = 1'b1;
      tick(1); step = 1'b0;
      tick(6);
      check("wrap_retired", {16'd0, retired}, 32'd0);

      // Reset taken while in EXEC.
      rw0 = n_rw; ir_op = 4'd3; run = 1'b1;
      wait_exec("exec_reset_timeout");
      reset_n = 1'b0; run = 1'b0;
      @(negedge clock);
      check("exec_reset_outputs", {3'd0, outs}, 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      tick(2);
      check("exec_reset_no_write", n_rw - rw0, 32'd0);

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         run      = ($urandom_range(3) != 0);
         step     = ($urandom_range(7) == 0);
         imem_ack = ($urandom_range(2) != 0);
         ir_op    = ($urandom_range(15) == 0) ? 4'(8 + $urandom_range(7)) : 4'($urandom_range(7));
         reset_n  = ($urandom_range(149) != 0);
         tick(1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
